// File: rtl/jt51_wrdec_pkg.sv
// jt51_wrdec shared definitions
// Register map, hold length and strobe decode helper.
package jt51_wrdec_pkg;

  localparam int HOLD_DEF = 32;

  localparam logic [7:0] REG_KON    = 8'h08;
  localparam logic [7:0] REG_NOISE  = 8'h0F;
  localparam logic [7:0] REG_CLKA1  = 8'h10;
  localparam logic [7:0] REG_CLKA2  = 8'h11;
  localparam logic [7:0] REG_CLKB   = 8'h12;
  localparam logic [7:0] REG_TIMCTL = 8'h14;
  localparam logic [7:0] REG_LFRQ   = 8'h18;
  localparam logic [7:0] REG_PMDAMD = 8'h19;
  localparam logic [7:0] REG_CTW    = 8'h1B;

  localparam logic [7:0] REG_RL     = 8'h20;
  localparam logic [7:0] REG_KC     = 8'h28;
  localparam logic [7:0] REG_KF     = 8'h30;
  localparam logic [7:0] REG_PMS    = 8'h38;
  localparam logic [7:0] REG_DT1    = 8'h40;
  localparam logic [7:0] REG_TL     = 8'h60;
  localparam logic [7:0] REG_KS     = 8'h80;
  localparam logic [7:0] REG_AMS    = 8'hA0;
  localparam logic [7:0] REG_DT2    = 8'hC0;
  localparam logic [7:0] REG_D1L    = 8'hE0;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_RL,
    SEL_KC,
    SEL_KF,
    SEL_PMS,
    SEL_DT1,
    SEL_TL,
    SEL_KS,
    SEL_AMS,
    SEL_DT2,
    SEL_D1L,
    SEL_KON
  } sel_e;

  // Channel regs span 8 addresses, operator regs span 32.
  function automatic sel_e strobe_sel(
    input logic [7:0] a
  );
    sel_e s;
    s = SEL_NONE;
    unique case (1'b1)
      a == REG_KON:              s = SEL_KON;
      a[7:3] == REG_RL[7:3]:     s = SEL_RL;
      a[7:3] == REG_KC[7:3]:     s = SEL_KC;
      a[7:3] == REG_KF[7:3]:     s = SEL_KF;
      a[7:3] == REG_PMS[7:3]:    s = SEL_PMS;
      a[7:5] == REG_DT1[7:5]:    s = SEL_DT1;
      a[7:5] == REG_TL[7:5]:     s = SEL_TL;
      a[7:5] == REG_KS[7:5]:     s = SEL_KS;
      a[7:5] == REG_AMS[7:5]:    s = SEL_AMS;
      a[7:5] == REG_DT2[7:5]:    s = SEL_DT2;
      a[7:5] == REG_D1L[7:5]:    s = SEL_D1L;
      default:                   s = SEL_NONE;
    endcase
    return s;
  endfunction

  function automatic logic is_op_reg(
    input logic [7:0] a
  );
    return a[7:6] != 2'b00;
  endfunction

endpackage

// File: rtl/jt51_wrdec_if.sv
// jt51_wrdec CPU bus bundle
// Raw YM2151 write strobes, address select and data.
interface jt51_wrdec_if;
  import jt51_wrdec_pkg::*;

  logic       cs_n;
  logic       wr_n;
  logic       a0;
  logic [7:0] din;

  modport master (
    output cs_n,
    output wr_n,
    output a0,
    output din
  );

  modport slave (
    input cs_n,
    input wr_n,
    input a0,
    input din
  );

endinterface

// File: rtl/jt51_wrdec_glob.sv
// jt51_wrdec global register file
// Noise, timer, LFO and control-terminal registers.
module jt51_wrdec_glob
  import jt51_wrdec_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  output logic       ne,
  output logic [4:0] nfrq,
  output logic [9:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       en_irq_A,
  output logic       en_irq_B,
  output logic       csm,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  output logic [7:0] lfo_freq,
  output logic [1:0] lfo_w,
  output logic [6:0] amd,
  output logic [6:0] pmd,
  output logic       ct1,
  output logic       ct2
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ne         <= 1'b0;
      nfrq       <= '0;
      value_A    <= '0;
      value_B    <= '0;
      load_A     <= 1'b0;
      load_B     <= 1'b0;
      en_irq_A   <= 1'b0;
      en_irq_B   <= 1'b0;
      csm        <= 1'b0;
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      lfo_freq   <= '0;
      lfo_w      <= '0;
      amd        <= '0;
      pmd        <= '0;
      ct1        <= 1'b0;
      ct2        <= 1'b0;
    end else begin
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      if (wr) begin
        unique case (1'b1)
          addr == REG_NOISE: begin
            ne   <= din[7];
            nfrq <= din[4:0];
          end
          addr == REG_CLKA1:
            value_A[9:2] <= din;
          addr == REG_CLKA2:
            value_A[1:0] <= din[1:0];
          addr == REG_CLKB:
            value_B <= din;
          addr == REG_TIMCTL: begin
            csm        <= din[7];
            clr_flag_B <= din[5];
            clr_flag_A <= din[4];
            en_irq_B   <= din[3];
            en_irq_A   <= din[2];
            load_B     <= din[1];
            load_A     <= din[0];
          end
          addr == REG_LFRQ:
            lfo_freq <= din;
          addr == REG_PMDAMD: begin
            if (din[7]) pmd <= din[6:0];
            else        amd <= din[6:0];
          end
          addr == REG_CTW: begin
            ct2   <= din[7];
            ct1   <= din[6];
            lfo_w <= din[1:0];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/jt51_wrdec.sv
// jt51_wrdec top: write edge detect, address latch,
// hold FSM and per-channel/operator update strobes.
module jt51_wrdec
  import jt51_wrdec_pkg::*;
#(
  parameter int HOLD = HOLD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  jt51_wrdec_if.slave bus,
  output logic       busy,
  output logic [7:0] reg_din,
  output logic [1:0] op,
  output logic [2:0] ch,
  output logic       up_rl,
  output logic       up_kc,
  output logic       up_kf,
  output logic       up_pms,
  output logic       up_dt1,
  output logic       up_tl,
  output logic       up_ks,
  output logic       up_amsen,
  output logic       up_dt2,
  output logic       up_d1l,
  output logic       up_keyon,
  output logic       ne,
  output logic [4:0] nfrq,
  output logic [9:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       en_irq_A,
  output logic       en_irq_B,
  output logic       csm,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  output logic [7:0] lfo_freq,
  output logic [1:0] lfo_w,
  output logic [6:0] amd,
  output logic [6:0] pmd,
  output logic       ct1,
  output logic       ct2
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
  localparam logic [4:0] LAST    = 5'(HOLD - 1);

  logic [0:0] state;
  logic [4:0] hcnt;
  logic [7:0] addr;
  logic       we;
  logic       we_q;
  logic       ev;
  logic       dwr;
  sel_e       sel;
  sel_e       wsel;

  assign we   = !bus.cs_n && !bus.wr_n;
  assign ev   = we && !we_q;
  // Data writes landing while an update is held are discarded.
  assign dwr  = ev && bus.a0 && (state == ST_IDLE);
  assign wsel = strobe_sel(addr);
  assign busy = state == ST_HOLD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      hcnt    <= '0;
      addr    <= '0;
      we_q    <= 1'b0;
      sel     <= SEL_NONE;
      reg_din <= '0;
      op      <= '0;
      ch      <= '0;
    end else begin
      we_q <= we;
      if (ev && !bus.a0)
        addr <= bus.din;
      if (state == ST_IDLE) begin
        if (dwr) begin
          reg_din <= bus.din;
          sel     <= wsel;
          hcnt    <= '0;
          state   <= ST_HOLD;
          if (wsel != SEL_NONE) begin
            op <= is_op_reg(addr) ? addr[4:3] : 2'd0;
            ch <= (wsel == SEL_KON) ?
                  bus.din[2:0] : addr[2:0];
          end
        end
      end else if (cen) begin
        hcnt <= hcnt + 5'd1;
        if (hcnt == LAST) begin
          state <= ST_IDLE;
          sel   <= SEL_NONE;
        end
      end
    end
  end

  assign up_rl    = sel == SEL_RL;
  assign up_kc    = sel == SEL_KC;
  assign up_kf    = sel == SEL_KF;
  assign up_pms   = sel == SEL_PMS;
  assign up_dt1   = sel == SEL_DT1;
  assign up_tl    = sel == SEL_TL;
  assign up_ks    = sel == SEL_KS;
  assign up_amsen = sel == SEL_AMS;
  assign up_dt2   = sel == SEL_DT2;
  assign up_d1l   = sel == SEL_D1L;
  assign up_keyon = sel == SEL_KON;

  jt51_wrdec_glob u_glob (
    .clk        (clk),
    .rst        (rst),
    .wr         (dwr),
    .addr       (addr),
    .din        (bus.din),
    .ne         (ne),
    .nfrq       (nfrq),
    .value_A    (value_A),
    .value_B    (value_B),
    .load_A     (load_A),
    .load_B     (load_B),
    .en_irq_A   (en_irq_A),
    .en_irq_B   (en_irq_B),
    .csm        (csm),
    .clr_flag_A (clr_flag_A),
    .clr_flag_B (clr_flag_B),
    .lfo_freq   (lfo_freq),
    .lfo_w      (lfo_w),
    .amd        (amd),
    .pmd        (pmd),
    .ct1        (ct1),
    .ct2        (ct2)
  );

endmodule

// File: tb/tb_jt51_wrdec.sv
// tb_jt51_wrdec: directed scoreboard bench
// for the JT51 CPU write decoder.
module tb_jt51_wrdec;
  import jt51_wrdec_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic       busy;
  logic [7:0] reg_din;
  logic [1:0] op;
  logic [2:0] ch;
  logic       up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl;
  logic       up_ks, up_amsen, up_dt2, up_d1l, up_keyon;
  logic       ne;
  logic [4:0] nfrq;
  logic [9:0] value_A;
  logic [7:0] value_B;
  logic       load_A, load_B, en_irq_A, en_irq_B, csm;
  logic       clr_flag_A, clr_flag_B;
  logic [7:0] lfo_freq;
  logic [1:0] lfo_w;
  logic [6:0] amd, pmd;
  logic       ct1, ct2;

  jt51_wrdec_if bus ();

  jt51_wrdec #(.HOLD(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .bus        (bus.slave),
    .busy       (busy),
    .reg_din    (reg_din),
    .op         (op),
    .ch         (ch),
    .up_rl      (up_rl),
    .up_kc      (up_kc),
    .up_kf      (up_kf),
    .up_pms     (up_pms),
    .up_dt1     (up_dt1),
    .up_tl      (up_tl),
    .up_ks      (up_ks),
    .up_amsen   (up_amsen),
    .up_dt2     (up_dt2),
    .up_d1l     (up_d1l),
    .up_keyon   (up_keyon),
    .ne         (ne),
    .nfrq       (nfrq),
    .value_A    (value_A),
    .value_B    (value_B),
    .load_A     (load_A),
    .load_B     (load_B),
    .en_irq_A   (en_irq_A),
    .en_irq_B   (en_irq_B),
    .csm        (csm),
    .clr_flag_A (clr_flag_A),
    .clr_flag_B (clr_flag_B),
    .lfo_freq   (lfo_freq),
    .lfo_w      (lfo_w),
    .amd        (amd),
    .pmd        (pmd),
    .ct1        (ct1),
    .ct2        (ct2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cen <= ~cen;

  // bit order: rl kc kf pms dt1 tl ks ams dt2 d1l kon
  wire [10:0] ups = {up_rl, up_kc, up_kf, up_pms,
                     up_dt1, up_tl, up_ks, up_amsen,
                     up_dt2, up_d1l, up_keyon};

  localparam logic [10:0] U_NONE = 11'd0;
  localparam logic [10:0] U_KC   = 11'b010_0000_0000;
  localparam logic [10:0] U_DT1  = 11'b000_0100_0000;
  localparam logic [10:0] U_TL   = 11'b000_0010_0000;
  localparam logic [10:0] U_KON  = 11'b000_0000_0001;

  typedef struct {
    logic [10:0] up;
    logic [1:0]  op;
    logic [2:0]  ch;
    logic [7:0]  d;
    bit          opch;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic a, input logic [7:0] d);
    @(negedge clk);
    bus.cs_n = 1'b0;
    bus.wr_n = 1'b0;
    bus.a0   = a;
    bus.din  = d;
    @(negedge clk);
    bus.cs_n = 1'b1;
    bus.wr_n = 1'b1;
  endtask

  task automatic data_wr(input logic [7:0] d,
                         input logic [10:0] up,
                         input logic [1:0] eop,
                         input logic [2:0] ech,
                         input bit opch);
    exp_t e;
    e.up = up; e.op = eop; e.ch = ech;
    e.d = d; e.opch = opch;
    sb.push_back(e);
    bus_wr(1'b1, d);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    for (int i = 0; i < 8 && busy !== 1'b1; i++)
      @(negedge clk);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_up"}, 32'(ups), 32'(e.up));
      chk({tag, "_din"}, 32'(reg_din), 32'(e.d));
      if (e.opch) begin
        chk({tag, "_op"}, 32'(op), 32'(e.op));
        chk({tag, "_ch"}, 32'(ch), 32'(e.ch));
      end
    end
  endtask

  // Walks the hold from the current negedge until busy drops,
  // optionally injecting one bus write at cen count inj_at.
  task automatic hold(input int inj_at,
                      input logic inj_a0,
                      input logic [7:0] inj_d,
                      output int ncen,
                      output int nstr,
                      output int ncyc,
                      output int nclr);
    bit inj;
    inj = 0; ncen = 0; nstr = 0; ncyc = 0; nclr = 0;
    while (busy === 1'b1 && ncyc < 500) begin
      ncyc++;
      if (cen) ncen++;
      if (ups != 0) nstr++;
      if (clr_flag_A || clr_flag_B) nclr++;
      if (!inj && ncen == inj_at) begin
        inj = 1;
        bus.cs_n = 1'b0;
        bus.wr_n = 1'b0;
        bus.a0   = inj_a0;
        bus.din  = inj_d;
        @(negedge clk);
        bus.cs_n = 1'b1;
        bus.wr_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nc, ns, ny, nk, cnt;
    bus.cs_n = 1'b1;
    bus.wr_n = 1'b1;
    bus.a0   = 1'b0;
    bus.din  = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ups", 32'(ups), 32'd0);
    chk("rst_din", 32'(reg_din), 32'd0);
    chk("rst_va", 32'(value_A), 32'd0);
    rst = 1'b0;

    // KC write, channel 0
    bus_wr(1'b0, 8'h28);
    data_wr(8'h4A, U_KC, 2'd0, 3'd0, 1);
    sb_check("kc");
    hold(-1, 1'b0, 8'h00, nc, ns, ny, nk);
    chk("kc_cen", 32'(nc), 32'd32);
    chk("kc_str", 32'(ns), 32'(ny));
    chk("kc_clk", 32'(ny == 63 || ny == 64), 32'd1);
    chk("kc_end_ups", 32'(ups), 32'd0);
    chk("kc_keep_din", 32'(reg_din), 32'h4A);

    // DT1 op3 ch3, second data write dropped
    bus_wr(1'b0, 8'h5B);
    data_wr(8'h1F, U_DT1, 2'd3, 3'd3, 1);
    sb_check("dt1");
    hold(10, 1'b1, 8'hFF, nc, ns, ny, nk);
    chk("dt1_cen", 32'(nc), 32'd32);
    chk("dt1_str", 32'(ns), 32'(ny));
    chk("dt1_drop_din", 32'(reg_din), 32'h1F);
    chk("dt1_keep_op", 32'(op), 32'd3);

    // key-on, address write 14 accepted mid-hold
    bus_wr(1'b0, 8'h08);
    data_wr(8'h7E, U_KON, 2'd0, 3'd6, 1);
    sb_check("kon");
    hold(5, 1'b0, 8'h14, nc, ns, ny, nk);
    chk("kon_cen", 32'(nc), 32'd32);
    chk("kon_keep_ch", 32'(ch), 32'd6);

    // timer control via the address latched above
    data_wr(8'h35, U_NONE, 2'd0, 3'd0, 0);
    sb_check("tim");
    chk("tim_csm", 32'(csm), 32'd0);
    chk("tim_irqA", 32'(en_irq_A), 32'd1);
    chk("tim_irqB", 32'(en_irq_B), 32'd0);
    chk("tim_ldA", 32'(load_A), 32'd1);
    chk("tim_ldB", 32'(load_B), 32'd0);
    chk("tim_clrA", 32'(clr_flag_A), 32'd1);
    chk("tim_clrB", 32'(clr_flag_B), 32'd1);
    hold(-1, 1'b0, 8'h00, nc, ns, ny, nk);
    chk("tim_cen", 32'(nc), 32'd32);
    chk("tim_nostr", 32'(ns), 32'd0);
    chk("tim_clr_1cyc", 32'(nk), 32'd1);

    // timer A preload
    bus_wr(1'b0, 8'h10);
    data_wr(8'hC5, U_NONE, 2'd0, 3'd0, 0);
    sb_check("va_hi");
    hold(-1, 1'b0, 8'h00, nc, ns, ny, nk);
    bus_wr(1'b0, 8'h11);
    data_wr(8'h03, U_NONE, 2'd0, 3'd0, 0);
    sb_check("va_lo");
    chk("va", 32'(value_A), 32'h317);
    hold(-1, 1'b0, 8'h00, nc, ns, ny, nk);

    // PMD written, AMD untouched
    bus_wr(1'b0, 8'h19);
    data_wr(8'h85, U_NONE, 2'd0, 3'd0, 0);
    sb_check("pmd");
    chk("pmd", 32'(pmd), 32'h05);
    chk("amd", 32'(amd), 32'h00);
    hold(-1, 1'b0, 8'h00, nc, ns, ny, nk);

    // control terminals and LFO wave
    bus_wr(1'b0, 8'h1B);
    data_wr(8'hC2, U_NONE, 2'd0, 3'd0, 0);
    sb_check("ctw");
    chk("ct2", 32'(ct2), 32'd1);
    chk("ct1", 32'(ct1), 32'd1);
    chk("lfo_w", 32'(lfo_w), 32'd2);
    hold(-1, 1'b0, 8'h00, nc, ns, ny, nk);

    // TL hold aborted by reset at cen 20
    bus_wr(1'b0, 8'h60);
    data_wr(8'h3C, U_TL, 2'd0, 3'd0, 1);
    sb_check("tl");
    cnt = 0;
    for (int i = 0; i < 200 && cnt < 20; i++) begin
      if (cen) cnt++;
      @(negedge clk);
    end
    chk("tl_reach20", 32'(cnt), 32'd20);
    chk("tl_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_ups", 32'(ups), 32'd0);
    chk("ab_va", 32'(value_A), 32'd0);
    chk("ab_pmd", 32'(pmd), 32'd0);
    chk("ab_irqA", 32'(en_irq_A), 32'd0);
    chk("ab_ct1", 32'(ct1), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // clean KC hold after the abort
    bus_wr(1'b0, 8'h2A);
    data_wr(8'h11, U_KC, 2'd0, 3'd2, 1);
    sb_check("kc2");
    hold(-1, 1'b0, 8'h00, nc, ns, ny, nk);
    chk("kc2_cen", 32'(nc), 32'd32);
    chk("kc2_str", 32'(ns), 32'(ny));
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
